dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl_pkg.sv | 30 +++
 rtl/dcache_sram.sv | 48 ++++
 rtl/dcache_ctrl.sv | 137 +++++++++++++
 tb/tb_dcache_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared field geometry and FSM state encodings for the direct-mapped data cache.
package dcache_ctrl_pkg;

  localparam int TAG_W    = 22;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 5;
  localparam int WORD_W   = 3;

  // Byte-address field positions: tag [31:10], index [9:5], word [4:2].
  localparam int WORD_LSB  = 2;
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_LSB   = OFFSET_W + INDEX_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;
  localparam logic [1:0] ST_REFILL    = 2'd3;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } line_meta_t;

  function automatic logic [31:0] line_base(input logic [TAG_W-1:0]   tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read of one line, one synchronous write port.
module dcache_sram
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INDEX_W-1:0]   rd_index,
  output line_meta_t           rd_meta,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 we,
  input  logic [INDEX_W-1:0]   wr_index,
  input  line_meta_t           wr_meta,
  input  logic [LINE_BITS-1:0] wr_data
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= wr_meta.valid;
      dirty_q[wr_index] <= wr_meta.dirty;
    end
  end

  // NOTE: tag and data arrays carry no reset so they map onto plain RAM; cleared valid bits hide stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_meta.tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_meta.valid = valid_q[rd_index];
  assign rd_meta.dirty = dirty_q[rd_index];
  assign rd_meta.tag   = tag_mem[rd_index];
  assign rd_data       = data_mem[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller between the CPU MEM stage and a line-wide memory.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_addr_i,
  input  logic [31:0]          p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  logic [1:0]           state_q;
  logic [1:0]           state_d;

  logic [TAG_W-1:0]     addr_tag;
  logic [INDEX_W-1:0]   addr_index;
  logic [WORD_W-1:0]    addr_word;
  logic [7:0]           word_bit;
  logic                 req;
  logic                 hit;

  line_meta_t           rd_meta;
  logic [LINE_BITS-1:0] rd_data;
  logic [LINE_BITS-1:0] store_line;
  logic                 sram_we;
  line_meta_t           wr_meta;
  logic [LINE_BITS-1:0] wr_line;

  logic                 unused_byte_bits;

  assign addr_tag   = p1_addr_i[31:TAG_LSB];
  assign addr_index = p1_addr_i[TAG_LSB-1:INDEX_LSB];
  assign addr_word  = p1_addr_i[INDEX_LSB-1:WORD_LSB];
  assign word_bit   = {addr_word, 5'b0};
  assign unused_byte_bits = ^p1_addr_i[WORD_LSB-1:0];

  assign req = p1_MemRead_i | p1_MemWrite_i;
  assign hit = rd_meta.valid && (rd_meta.tag == addr_tag);

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk      (clk_i),
    .rst_n    (rst_i),
    .rd_index (addr_index),
    .rd_meta  (rd_meta),
    .rd_data  (rd_data),
    .we       (sram_we),
    .wr_index (addr_index),
    .wr_meta  (wr_meta),
    .wr_data  (wr_line)
  );

  assign p1_data_o  = hit ? rd_data[word_bit +: 32] : 32'd0;
  assign mem_data_o = rd_data;

  always_comb begin
    store_line = rd_data;
    store_line[word_bit +: 32] = p1_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    p1_stall_o    = 1'b0;
    mem_enable_o  = 1'b0;
    mem_write_o   = 1'b0;
    mem_addr_o    = {p1_addr_i[31:INDEX_LSB], {OFFSET_W{1'b0}}};
    sram_we       = 1'b0;
    wr_meta.valid = 1'b1;
    wr_meta.dirty = 1'b0;
    wr_meta.tag   = addr_tag;
    wr_line       = mem_data_i;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            // A store wins when both strobes are high.
            if (p1_MemWrite_i) begin
              sram_we       = 1'b1;
              wr_meta.dirty = 1'b1;
              wr_line       = store_line;
            end
          end else begin
            p1_stall_o = 1'b1;
            state_d    = (rd_meta.valid && rd_meta.dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end

      ST_WRITEBACK: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = line_base(rd_meta.tag, addr_index);
        if (mem_ack_i) state_d = ST_ALLOCATE;
      end

      ST_ALLOCATE: begin
        p1_stall_o   = 1'b1;
        mem_enable_o = 1'b1;
        if (mem_ack_i) begin
          sram_we = 1'b1;
          state_d = ST_REFILL;
        end
      end

      ST_REFILL: begin
        // One settle cycle so the re-presented access sees the new line as a hit.
        p1_stall_o = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed and randomized bench for dcache_ctrl against a flat coherent-memory reference model.
module tb_dcache_ctrl;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;
  int spur_req = 0;
  int spur_done = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t txn_q[$];
  int   txn_rd = 0;

  // backing: main memory contents; gold: what every load must return.
  logic [31:0] backing [int unsigned];
  logic [31:0] gold    [int unsigned];
  bit          mvalid  [32];
  bit          mdirty  [32];
  logic [21:0] mtag    [32];

  dcache_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    if (a == 32'h0000_0404) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h1234_ABCD;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return mem_init(a);
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return mem_rd(a);
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = gold_rd(base + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [255:0] backing_line(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_rd(base + 32'(w * 4));
    return l;
  endfunction

  // Memory: acks ack_delay cycles after it first sees mem_enable_o, one-cycle pulse.
  initial begin
    int   wait_cnt;
    txn_t t;
    wait_cnt   = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (spur_done != spur_req) begin
        spur_done++;
        mem_data_i = {8{32'hBADB_AD00}};
        mem_ack_i  = 1'b1;
      end else if (mem_enable_o === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          t.wr   = mem_write_o;
          t.addr = mem_addr_o;
          t.data = mem_data_o;
          txn_q.push_back(t);
          if (mem_write_o === 1'b1) begin
            for (int w = 0; w < 8; w++) backing[mem_addr_o + 32'(w * 4)] = mem_data_o[w*32 +: 32];
          end else begin
            mem_data_i = backing_line(mem_addr_o);
          end
          mem_ack_i = 1'b1;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    gold.delete();
  endtask

  task automatic idle_check(input logic [31:0] a);
    bit hit;
    p1_addr_i     = a;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    #1;
    hit = mvalid[a[9:5]] && (mtag[a[9:5]] == a[31:10]);
    check("idle_stall", 256'(p1_stall_o), 256'(0));
    check("idle_enable", 256'(mem_enable_o), 256'(0));
    check("idle_data", 256'(p1_data_o), 256'(hit ? gold_rd({a[31:2], 2'b00}) : 32'd0));
    @(negedge clk_i);
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr);
    logic [4:0]   idx;
    logic [21:0]  tg;
    logic [31:0]  base, wa, victim_base;
    logic [255:0] victim_line;
    bit           hit, victim_dirty;
    int           lat, exp_stalls, exp_txn, stalls;
    idx          = a[9:5];
    tg           = a[31:10];
    base         = {a[31:5], 5'b0};
    wa           = {a[31:2], 2'b00};
    hit          = mvalid[idx] && (mtag[idx] == tg);
    victim_dirty = !hit && mvalid[idx] && mdirty[idx];
    victim_base  = {mtag[idx], idx, 5'b0};
    victim_line  = gold_line(victim_base);
    lat          = ack_delay + 1;
    exp_stalls   = hit ? 0 : (victim_dirty ? 2 * lat + 2 : lat + 2);
    exp_txn      = hit ? 0 : (victim_dirty ? 2 : 1);

    p1_addr_i     = a;
    p1_data_i     = d;
    p1_MemRead_i  = rd;
    p1_MemWrite_i = wr;
    stalls = 0;
    #1;
    while (p1_stall_o !== 1'b0 && stalls < 400) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    check("stall_cycles", 256'(stalls), 256'(exp_stalls));
    if (rd && !wr) check("load_data", 256'(p1_data_o), 256'(gold_rd(wa)));
    if (wr) gold[wa] = d;

    check("txn_count", 256'(txn_q.size() - txn_rd), 256'(exp_txn));
    if (victim_dirty && txn_q.size() > txn_rd) begin
      check("wb_write", 256'(txn_q[txn_rd].wr), 256'(1));
      check("wb_addr", 256'(txn_q[txn_rd].addr), 256'(victim_base));
      check("wb_line", txn_q[txn_rd].data, victim_line);
      txn_rd++;
    end
    if (!hit && txn_q.size() > txn_rd) begin
      check("fill_write", 256'(txn_q[txn_rd].wr), 256'(0));
      check("fill_addr", 256'(txn_q[txn_rd].addr), 256'(base));
      txn_rd++;
    end
    txn_rd = txn_q.size();

    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    mdirty[idx] = hit ? (mdirty[idx] | wr) : wr;

    @(negedge clk_i);
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    #1;
    check("enable_after", 256'(mem_enable_o), 256'(0));
    @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    rst_i         = 1'b0;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    model_reset();

    repeat (2) @(negedge clk_i);
    #1;
    check("reset_stall", 256'(p1_stall_o), 256'(0));
    check("reset_enable", 256'(mem_enable_o), 256'(0));
    check("reset_write", 256'(mem_write_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Cold load, then store hit and reload on the same line.
    ack_delay = 0;
    access(32'h0000_0404, 32'd0, 1'b1, 1'b0);
    if (txn_q.size() > 0) check("cold_fill_addr", 256'(txn_q[0].addr), 256'(32'h0000_0400));
    p1_addr_i = 32'h0000_0404;
    #1;
    check("cold_load_word", 256'(p1_data_o), 256'(32'hDEAD_BEEF));
    @(negedge clk_i);
    access(32'h0000_0404, 32'h1234_5678, 1'b0, 1'b1);
    access(32'h0000_0404, 32'd0, 1'b1, 1'b0);

    // Conflict miss on a dirty line.
    ack_delay = 2;
    access(32'h0000_0804, 32'd0, 1'b1, 1'b0);
    if (txn_q.size() >= 2) check("wb_word1", 256'(txn_q[txn_q.size()-2].data[63:32]), 256'(32'h1234_5678));

    // Both strobes high counts as a store.
    ack_delay = 0;
    access(32'h0000_0808, 32'hCAFE_F00D, 1'b1, 1'b1);
    access(32'h0000_0808, 32'd0, 1'b1, 1'b0);

    // Long memory latency.
    ack_delay = 10;
    access(32'h0000_0020, 32'd0, 1'b1, 1'b0);
    ack_delay = 0;
    access(32'h0000_0020, 32'h0000_55AA, 1'b0, 1'b1);

    // Reset in the middle of a fill, with late acks.
    ack_delay     = 1000;
    p1_addr_i     = 32'h0000_0064;
    p1_MemRead_i  = 1'b1;
    p1_MemWrite_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("alloc_enable", 256'(mem_enable_o), 256'(1));
    check("alloc_write", 256'(mem_write_o), 256'(0));
    check("alloc_addr", 256'(mem_addr_o), 256'(32'h0000_0060));
    check("alloc_stall", 256'(p1_stall_o), 256'(1));
    #2;
    rst_i = 1'b0;
    #1;
    check("rst_enable", 256'(mem_enable_o), 256'(0));
    check("rst_write", 256'(mem_write_o), 256'(0));
    p1_MemRead_i = 1'b0;
    #1;
    check("rst_stall", 256'(p1_stall_o), 256'(0));
    spur_req++;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    spur_req++;
    model_reset();
    ack_delay = 0;
    repeat (3) @(negedge clk_i);
    txn_rd = txn_q.size();
    idle_check(32'h0000_0064);
    idle_check(32'h0000_0404);
    access(32'h0000_0064, 32'd0, 1'b1, 1'b0);

    // Randomized traffic over a few indices and tags to force conflicts.
    for (int n = 0; n < 80; n++) begin
      ack_delay = $urandom_range(0, 3);
      a    = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      kind = $urandom_range(0, 3);
      case (kind)
        0:       idle_check(a);
        1:       access(a, 32'd0, 1'b1, 1'b0);
        2:       access(a, $urandom, 1'b0, 1'b1);
        default: access(a, $urandom, 1'b1, 1'b1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
